// File: rtl/uart_rx_os_if.sv
// Bus-side view of the oversampling UART receiver: SPART-style chip select,
// read strobe and address going in; received character and status flags
// coming back.
interface uart_rx_os_if #(
   parameter int DATA_BITS = 8
);
   logic                 iocs;
   logic                 iorw;
   logic [1:0]           ioaddr;
   logic [DATA_BITS-1:0] data;
   logic                 rda;
   logic                 fe;
   logic                 pe;
   logic                 oe;

   // Bus host: drives the access strobes, reads back data and status.
   modport master (
      output iocs, iorw, ioaddr,
      input  data, rda, fe, pe, oe
   );

   // Receiver: consumes the access strobes, presents data and status.
   modport slave (
      input  iocs, iorw, ioaddr,
      output data, rda, fe, pe, oe
   );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver.
// rxd is synchronised, the start bit is validated at mid-bit, then each data,
// parity and stop bit is sampled once every OS_RATE ticks of en_os. A finished
// frame is committed to the bus registers one clock after its last stop sample.
// Optional feature: define UART_RX_PARITY_EN to compile in the parity state and
// checker (PARITY: 0 none, 1 even, 2 odd). Without it, pe is tied low.
module uart_rx_os #(
   parameter int DATA_BITS = 8,
   parameter int OS_RATE   = 16,
   parameter int STOP_BITS = 1,
   parameter int PARITY    = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en_os,
   input  logic          rxd,
   output logic          busy,
   uart_rx_os_if.slave   bus
);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
   localparam bit PAR_ON = (PARITY != 0);
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   localparam int OS_W = $clog2(OS_RATE);
   localparam int BC_W = 4;
   localparam logic [OS_W-1:0] OS_MID  = OS_W'(OS_RATE / 2 - 1);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_RATE - 1);
   localparam logic [BC_W-1:0] DB_LAST = BC_W'(DATA_BITS - 1);
   localparam logic [BC_W-1:0] SB_LAST = BC_W'(STOP_BITS - 1);

   state_t                 state_reg;
   logic [OS_W-1:0]        os_cnt_reg;
   logic [BC_W-1:0]        bit_cnt_reg;
   logic [DATA_BITS-1:0]   shift_reg;
   logic [1:0]             sync_reg;
   logic                   rxd_s;
   logic                   busy_reg;
   logic                   commit_reg;
   logic                   pend_fe_reg;

   logic [DATA_BITS-1:0]   data_reg;
   logic                   rda_reg;
   logic                   fe_reg;
   logic                   oe_reg;
   logic                   pe_out;

   logic                   data_rd;
   logic                   stat_rd;
   logic                   load;

`ifdef UART_RX_PARITY_EN
   logic                   pend_pe_reg;
   logic                   pe_reg;
   logic                   par_exp;

   // Expected parity bit: even makes the total count of ones even.
   assign par_exp = (PARITY == 2) ? ~^shift_reg : ^shift_reg;
`endif

   assign rxd_s = sync_reg[1];

   // Two-flop synchroniser for the asynchronous serial line (idles high).
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], rxd};
      end
   end

   // Frame FSM: advances only on oversample ticks, commit pulse lasts one clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         os_cnt_reg  <= '0;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         busy_reg    <= 1'b0;
         commit_reg  <= 1'b0;
         pend_fe_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pend_pe_reg <= 1'b0;
`endif
      end else begin
         commit_reg <= 1'b0;
         if (en_os) begin
            case (state_reg)
               IDLE: begin
                  if (!rxd_s) begin
                     state_reg  <= START;
                     os_cnt_reg <= '0;
                     busy_reg   <= 1'b1;
                  end
               end
               START: begin
                  if (os_cnt_reg == OS_MID) begin
                     os_cnt_reg <= '0;
                     if (!rxd_s) begin
                        state_reg   <= DATA;
                        bit_cnt_reg <= '0;
                        pend_fe_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        pend_pe_reg <= 1'b0;
`endif
                     end else begin
                        // Glitch shorter than half a bit: drop it silently.
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                     end
                  end else begin
                     os_cnt_reg <= os_cnt_reg + 1'b1;
                  end
               end
               DATA: begin
                  if (os_cnt_reg == OS_LAST) begin
                     shift_reg  <= {rxd_s, shift_reg[DATA_BITS-1:1]};
                     os_cnt_reg <= '0;
                     if (bit_cnt_reg == DB_LAST) begin
                        bit_cnt_reg <= '0;
`ifdef UART_RX_PARITY_EN
                        state_reg   <= PAR_ON ? PAR : STOP;
`else
                        state_reg   <= STOP;
`endif
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     end
                  end else begin
                     os_cnt_reg <= os_cnt_reg + 1'b1;
                  end
               end
`ifdef UART_RX_PARITY_EN
               PAR: begin
                  if (os_cnt_reg == OS_LAST) begin
                     pend_pe_reg <= (rxd_s != par_exp);
                     os_cnt_reg  <= '0;
                     state_reg   <= STOP;
                  end else begin
                     os_cnt_reg <= os_cnt_reg + 1'b1;
                  end
               end
`endif
               STOP: begin
                  if (os_cnt_reg == OS_LAST) begin
                     os_cnt_reg <= '0;
                     if (!rxd_s) begin
                        pend_fe_reg <= 1'b1;
                     end
                     if (bit_cnt_reg == SB_LAST) begin
                        // Leave right away so a back-to-back start bit is caught.
                        bit_cnt_reg <= '0;
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                        commit_reg  <= 1'b1;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     end
                  end else begin
                     os_cnt_reg <= os_cnt_reg + 1'b1;
                  end
               end
               default: begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign data_rd = bus.iocs && bus.iorw && (bus.ioaddr == 2'b00);
   assign stat_rd = bus.iocs && bus.iorw && (bus.ioaddr == 2'b01);
   // A commit loads the holding register if it is free or being read right now.
   assign load    = commit_reg && (!rda_reg || data_rd);

   // Bus-side registers: commits set, reads clear, commit events win ties.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_reg <= '0;
         rda_reg  <= 1'b0;
         fe_reg   <= 1'b0;
         oe_reg   <= 1'b0;
      end else begin
         if (load) begin
            data_reg <= shift_reg;
            rda_reg  <= 1'b1;
         end else if (data_rd) begin
            rda_reg <= 1'b0;
         end

         if (commit_reg && !load) begin
            oe_reg <= 1'b1;
         end else if (stat_rd) begin
            oe_reg <= 1'b0;
         end

         if (commit_reg && pend_fe_reg) begin
            fe_reg <= 1'b1;
         end else if (stat_rd) begin
            fe_reg <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   // Sticky parity error, same set/clear rules as the framing flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         pe_reg <= 1'b0;
      end else if (commit_reg && pend_pe_reg) begin
         pe_reg <= 1'b1;
      end else if (stat_rd) begin
         pe_reg <= 1'b0;
      end
   end
   assign pe_out = pe_reg;
`else
   assign pe_out = 1'b0;
`endif

   assign bus.data = data_reg;
   assign bus.rda  = rda_reg;
   assign bus.fe   = fe_reg;
   assign bus.pe   = pe_out;
   assign bus.oe   = oe_reg;
   assign busy     = busy_reg;

endmodule

// File: tb/tb_uart_rx_os.sv
// Randomised scoreboard bench for uart_rx_os (8 data bits, 16x oversampling,
// 1 stop bit, en_os every cycle). Frames are serialised bit by bit; a
// behavioural model of the bus registers queues every expected change of
// {data, rda, fe, pe, oe}, and a monitor pops and compares on each change.
module tb_uart_rx_os;
   localparam int DB = 8;
   localparam int OS = 16;
   localparam int SB = 1;
`ifdef UART_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int PBITS = (PAR != 0) ? 1 : 0;
   localparam int NBITS = 1 + DB + PBITS + SB;
   // Clock offset (from driving the start bit) of the cycle in which the
   // commit is pending: 2 sync flops + detect edge, half a bit, then one full
   // bit per data/parity/stop bit.
   localparam int COMMIT_OFF = 3 + OS / 2 + (DB + PBITS + SB) * OS;

   logic clk = 1'b0;
   logic rst;
   logic en_os;
   logic rxd;
   logic busy;

   uart_rx_os_if #(.DATA_BITS(DB)) bus ();

   uart_rx_os #(
      .DATA_BITS (DB),
      .OS_RATE   (OS),
      .STOP_BITS (SB),
      .PARITY    (PAR)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .en_os (en_os),
      .rxd   (rxd),
      .busy  (busy),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DB-1:0] data;
      logic          rda;
      logic          fe;
      logic          pe;
      logic          oe;
   } obs_t;

   obs_t exp_q[$];
   obs_t model;
   obs_t prev;
   obs_t cur;
   obs_t e;
   bit   mon_on = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   // Monitor: every visible change of the bus outputs must match the next
   // expected state from the scoreboard.
   always @(negedge clk) begin
      if (mon_on) begin
         cur = {bus.data, bus.rda, bus.fe, bus.pe, bus.oe};
         if (cur != prev) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_change: got data=%h rda=%b fe=%b pe=%b oe=%b, none expected",
                        cur.data, cur.rda, cur.fe, cur.pe, cur.oe);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  miscompares++;
                  $display("FAIL outputs: got data=%h rda=%b fe=%b pe=%b oe=%b, exp data=%h rda=%b fe=%b pe=%b oe=%b",
                           cur.data, cur.rda, cur.fe, cur.pe, cur.oe, e.data, e.rda, e.fe, e.pe, e.oe);
               end else begin
                  $display("t=%0t obs data=%h rda=%b fe=%b pe=%b oe=%b", $time,
                           cur.data, cur.rda, cur.fe, cur.pe, cur.oe);
               end
            end
            prev = cur;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic model_push(input obs_t old);
      if (model != old) exp_q.push_back(model);
   endtask

   // Frame arrives: loads if the holding register is free (or read that same
   // cycle), otherwise overrun; error flags accumulate either way.
   task automatic m_commit(input logic [DB-1:0] ch, input bit bad_stop, input bit bad_par, input bit rd);
      obs_t old;
      old = model;
      if (!model.rda || rd) begin
         model.data = ch;
         model.rda  = 1'b1;
      end else begin
         model.oe = 1'b1;
      end
      if (bad_stop) model.fe = 1'b1;
      if (bad_par && PBITS == 1) model.pe = 1'b1;
      model_push(old);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_access(input logic rw, input logic [1:0] a);
      obs_t old;
      old = model;
      if (rw && a == 2'b00) model.rda = 1'b0;
      if (rw && a == 2'b01) begin
         model.fe = 1'b0;
         model.pe = 1'b0;
         model.oe = 1'b0;
      end
      model_push(old);
      bus.iocs   = 1'b1;
      bus.iorw   = rw;
      bus.ioaddr = a;
      tick(1);
      bus.iocs   = 1'b0;
      bus.iorw   = 1'b0;
      bus.ioaddr = 2'b00;
   endtask

   task automatic send_frame(input logic [DB-1:0] ch, input bit bad_stop, input bit bad_par, input bit rd_on_commit);
      logic [15:0] bits;
      bits    = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < DB; i++) bits[1 + i] = ch[i];
      if (PBITS == 1) bits[1 + DB] = ((PAR == 2) ? ~^ch : ^ch) ^ bad_par;
      bits[1 + DB + PBITS] = ~bad_stop;
      for (int c = 0; c < NBITS * OS; c++) begin
         rxd = bits[c / OS];
         if (c == (1 + DB + PBITS) * OS) m_commit(ch, bad_stop, bad_par, rd_on_commit);
         if (rd_on_commit && c == COMMIT_OFF) begin
            bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = 2'b00;
         end
         if (rd_on_commit && c == COMMIT_OFF + 1) begin
            bus.iocs = 1'b0; bus.iorw = 1'b0;
         end
         if (c == 3 * OS) chk("busy_mid_frame", {31'd0, busy}, 32'd1);
         tick(1);
      end
      rxd = 1'b1;
   endtask

   // Start a frame, send the start bit plus nbits data bits, then reset.
   task automatic abort_frame(input logic [DB-1:0] ch, input int nbits);
      rxd = 1'b0;
      tick(OS);
      for (int i = 0; i < nbits; i++) begin
         rxd = ch[i];
         tick(OS);
      end
      rst = 1'b1;
      rxd = 1'b1;
      model = '0;
      exp_q.push_back(model);
      tick(2);
      rst = 1'b0;
      chk("busy_after_reset", {31'd0, busy}, 32'd0);
      tick(2);
   endtask

   task automatic false_start(input int low_ticks);
      rxd = 1'b0;
      tick(low_ticks);
      rxd = 1'b1;
      tick(2);
      chk("busy_in_start", {31'd0, busy}, 32'd1);
      tick(OS);
      chk("busy_after_false_start", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DB-1:0] ch;
      int            act;
      rst = 1'b1; en_os = 1'b1; rxd = 1'b1;
      bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00;
      tick(4);
      chk("reset_outputs", {23'd0, bus.data, bus.rda, bus.fe, bus.pe, bus.oe},
          32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      rst   = 1'b0;
      model = '0;
      prev  = '0;
      mon_on = 1'b1;
      tick(4);

      // Clean frame, then a data read.
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      tick(2);
      bus_access(1'b1, 2'b00);
      tick(2);

      // Short low pulse is rejected at the mid-start check.
      false_start(4);

      // Framing error, cleared by a status read.
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      tick(2);
      bus_access(1'b1, 2'b01);
      bus_access(1'b1, 2'b00);

      // Back-to-back frames without a read: overrun.
      send_frame(8'h11, 1'b0, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0);
      tick(2);
      bus_access(1'b1, 2'b01);
      bus_access(1'b1, 2'b00);
      // Same again with a data read in the commit cycle of the second frame.
      send_frame(8'h11, 1'b0, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      tick(2);
      bus_access(1'b1, 2'b00);

`ifdef UART_RX_PARITY_EN
      // Bad then good parity on 0x07.
      send_frame(8'h07, 1'b0, 1'b1, 1'b0);
      tick(2);
      bus_access(1'b1, 2'b01);
      bus_access(1'b1, 2'b00);
      send_frame(8'h07, 1'b0, 1'b0, 1'b0);
      tick(2);
`endif

      // Reset after three data bits, then a clean frame.
      abort_frame(8'hFF, 3);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      tick(2);

      // Random traffic.
      for (int n = 0; n < 40; n++) begin
         ch  = DB'($urandom);
         act = $urandom_range(0, 15);
         if (act == 0) begin
            abort_frame(ch, $urandom_range(0, DB - 1));
         end else if (act == 1) begin
            false_start($urandom_range(1, OS / 2 - 2));
         end else begin
            send_frame(ch, ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 5) == 0));
            tick($urandom_range(0, 3));
            case ($urandom_range(0, 5))
               0: bus_access(1'b1, 2'b00);
               1: bus_access(1'b1, 2'b01);
               2: begin bus_access(1'b1, 2'b00); bus_access(1'b1, 2'b01); end
               3: bus_access(1'b0, 2'(($urandom_range(0, 3))));
               4: bus_access(1'b1, 2'(($urandom_range(2, 3))));
               default: ;
            endcase
         end
         tick($urandom_range(0, 12));
      end

      tick(10);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending expected changes, exp 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised UART receiver, next generation of the project's single-rate receiver.
- Samples rxd at an oversampled tick rate and validates the start bit at mid-bit.
- Supports configurable data width and stop-bit count.
- Flags framing, overrun and (optionally) parity errors.
- Sits between the baud generator (oversample tick) and the SPART bus interface (iocs/iorw/ioaddr).

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
OS_RATE, 16, enable ticks per bit period (power of 2, >= 4)
STOP_BITS, 1, stop bits checked (1 or 2)
PARITY, 0, 0 none / 1 even / 2 odd; used only when UART_RX_PARITY_EN is defined

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
en_os  input  1  oversample tick, one-cycle pulse at OS_RATE x baud
rxd  input  1  asynchronous serial input, idle high
iocs  input  1  chip select
iorw  input  1  1 = read, 0 = write (writes ignored)
ioaddr  input  2  00 = data, 01 = status
data  output  DATA_BITS  last received character
rda  output  1  receive data available
fe  output  1  framing error (sticky)
pe  output  1  parity error (sticky)
oe  output  1  overrun error (sticky)
busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Reset: data=0, rda=0, fe=0, pe=0, oe=0, busy=0; state IDLE; counters 0; both synchroniser flops=1. Reset mid-frame aborts the frame, with no flags and no data update.
- rxd passes through a 2-flop synchroniser to rxd_s. All FSM/counter activity advances only on cycles with en_os=1; otherwise state is held.
- os_cnt width is log2(OS_RATE) and it wraps naturally. bit_cnt counts data and stop bits.
- IDLE: on a tick with rxd_s=0, go to START with os_cnt=0.
- START: os_cnt increments each tick. At os_cnt==OS_RATE/2-1 (mid start bit):
  - rxd_s=0: go to DATA, os_cnt=0, bit_cnt=0.
  - rxd_s=1: false start, return to IDLE silently.
- DATA: at os_cnt==OS_RATE-1, shift rxd_s into the MSB of a DATA_BITS shift register (right shift, LSB first), set os_cnt=0, increment bit_cnt. After DATA_BITS samples go to PARITY (if compiled and PARITY!=0), otherwise STOP.
- PARITY: sample at os_cnt==OS_RATE-1 and compare against the computed parity; latch the mismatch into pending_pe. Then go to STOP.
- STOP: sample at os_cnt==OS_RATE-1, STOP_BITS times. Any stop sample of 0 latches pending_fe. After the final stop sample (frame commit), go to IDLE in the same tick. There is no wait to the end of the stop bit, so back-to-back frames are accepted.
- Frame commit, next cycle:
  - If rda=0, or a data read occurs in the commit cycle: data<=shift, rda<=1.
  - Else (rda=1, no read): data is kept, the new character is dropped, oe<=1.
  - fe |= pending_fe and pe |= pending_pe, regardless of overrun.
- Data read (iocs & iorw & ioaddr==00): rda<=0 next cycle, unless a commit loads in the same cycle, in which case the commit wins and rda stays 1.
- Status read (iocs & iorw & ioaddr==01): clears fe, pe, oe. A same-cycle commit error sets the flag and takes priority.
- Latency: data/rda update 1 clk after the tick sampling the last stop bit. Detect-to-commit = OS_RATE/2 + (DATA_BITS + parity + STOP_BITS) x OS_RATE ticks after the detection tick.
- ioaddr 10/11 and writes: no effect.

Optional Feature:
UART_RX_PARITY_EN
- Defined: PARITY state and checker are compiled in. PARITY=1 checks even parity, PARITY=2 checks odd parity, PARITY=0 behaves as no-parity. pe is driven by the checker.
- Undefined: no PARITY state, the PARITY parameter is ignored, pe is tied 0, and the frame is start + DATA_BITS + STOP_BITS.

Test Plan:
All scenarios use DATA_BITS=8, OS_RATE=16, STOP_BITS=1, en_os=1 every cycle.
1. Send 8N1 frame 0xA5 -> after the commit, data=0xA5, rda=1, fe=pe=oe=0. Data read -> rda=0 next cycle.
2. rxd low for 4 ticks, then high -> state returns to IDLE at the mid-start check, busy=0, rda stays 0, no flags.
3. Frame 0x3C with stop bit driven 0 -> data=0x3C, rda=1, fe=1. Status read -> fe=0; data and rda unchanged.
4. Frames 0x11 then 0x22 back-to-back, no read -> data=0x11, rda=1, oe=1. Data read on the 0x22 commit cycle instead -> data=0x22, rda=1, oe=0.
5. UART_RX_PARITY_EN defined, PARITY=1: send 0x07 with parity bit 0 -> data=0x07, rda=1, pe=1. Repeat with parity bit 1 after a status read -> pe=0.
6. Assert rst after 3 data bits of 0xFF -> all outputs 0, busy=0. Next frame 0x5A is received correctly: data=0x5A, rda=1, no flags.
